// File: rtl/fc_event_pkg.sv
// Shared types and the round-robin arbitration helper for the FC event queue.
package fc_event_pkg;

    localparam int EVENT_ID_WIDTH = 8;
    localparam int MAX_SOURCES    = 64;

    typedef logic [EVENT_ID_WIDTH-1:0] evt_id_t;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } arb_res_t;

    // Lowest offset from ptr (mod nb) wins; scanning high-to-low lets the last hit be the winner.
    function automatic arb_res_t rr_arbitrate(input logic [MAX_SOURCES-1:0] pending,
                                              input logic [5:0] ptr, input int nb);
        arb_res_t r;
        int       j;
        r = '0;
        for (int k = MAX_SOURCES - 1; k >= 0; k--) begin
            if (k < nb) begin
                j = int'(ptr) + k;
                if (j >= nb) j = j - nb;
                if (pending[j[5:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[5:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_event_fifo.sv
// Small synchronous FIFO for event IDs; head is read from registered storage, no bypass.
module fc_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_cnt;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fc_event_queue.sv
// Event pulse capture, round-robin arbitration and ID FIFO feeding the FC event interface.
// Optional saturating drop counter enabled by FC_EVENT_QUEUE_STATS_EN.
module fc_event_queue
    import fc_event_pkg::*;
#(
    parameter int NB_SOURCES     = 16,
    parameter int EVENT_ID_WIDTH = fc_event_pkg::EVENT_ID_WIDTH,
    parameter int EVT_BASE       = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_SOURCES-1:0]     evt_pulse_i,
    output logic                      event_fifo_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    input  logic                      event_fifo_fulln_i,
    output logic [NB_SOURCES-1:0]     lost_o,
    input  logic [NB_SOURCES-1:0]     lost_clr_i,
    output logic                      err_o
`ifdef FC_EVENT_QUEUE_STATS_EN
    ,
    output logic [15:0]               drop_cnt_o,
    input  logic                      drop_cnt_clr_i
`endif
);
    localparam int PW = $clog2(NB_SOURCES);

    logic [NB_SOURCES-1:0]     r_pend, r_lost, w_grant, w_lost_set;
    logic [PW-1:0]             r_ptr;
    logic                      r_err;
    logic [MAX_SOURCES-1:0]    w_pend64;
    arb_res_t                  w_arb;
    logic                      w_push, w_pop, w_full;
    logic [EVENT_ID_WIDTH-1:0] w_id;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    always_comb begin
        w_pend64                 = '0;
        w_pend64[NB_SOURCES-1:0] = r_pend;
        w_arb      = rr_arbitrate(w_pend64, 6'(r_ptr), NB_SOURCES);
        w_push     = w_arb.found && !w_full;
        w_grant    = '0;
        if (w_push) w_grant[w_arb.idx[PW-1:0]] = 1'b1;
        // A pulse on the source being granted is a fresh event, not a loss.
        w_lost_set = evt_pulse_i & r_pend & ~w_grant;
        w_id       = EVENT_ID_WIDTH'(EVT_BASE + int'(w_arb.idx));
    end

    assign w_pop  = event_fifo_valid_o && event_fifo_fulln_i;
    assign lost_o = r_lost;
    assign err_o  = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_lost <= '0;
            r_ptr  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | evt_pulse_i;
            r_lost <= (r_lost & ~lost_clr_i) | w_lost_set;
            r_err  <= |w_lost_set;
            if (w_push)
                r_ptr <= (int'(w_arb.idx) == NB_SOURCES - 1) ? '0 : PW'(int'(w_arb.idx) + 1);
        end
    end

    fc_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVENT_ID_WIDTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (w_id),
        .i_pop   (w_pop),
        .o_valid (event_fifo_valid_o),
        .o_data  (event_fifo_data_o),
        .o_full  (w_full),
        .o_count (w_count)
    );

`ifdef FC_EVENT_QUEUE_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [6:0]  w_inc;
    logic [16:0] w_sum;

    assign w_inc      = 7'($countones(w_lost_set));
    assign w_sum      = {1'b0, r_drop_cnt} + 17'(w_inc);
    assign drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               r_drop_cnt <= '0;
        else if (drop_cnt_clr_i) r_drop_cnt <= 16'(w_inc);
        else if (w_sum[16])      r_drop_cnt <= 16'hFFFF;
        else                     r_drop_cnt <= w_sum[15:0];
    end
`endif

endmodule
